frame_stats_collector: RTL and testbench
========================================

# frame_stats_collector

Receive-side consumer of the 8-bit synthetic pixel stream produced by the test-pattern generator. Accumulates per-frame statistics (pixel sum, min, max, horizontal-edge count, line count and line width, width consistency) and publishes one result set per frame over a valid/ready handshake. Sits between the generator/convolution output and the debug/readout logic, acting as a self-check of pattern content and stream geometry.

## Interface
- DATA_WIDTH, 8: pixel width.
- EDGE_THRESH, 128: an absolute horizontal difference at or above this value counts as an edge.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; closes the current frame and opens the next.
- pixel_in  in  DATA_WIDTH  pixel data.
- pixel_in_valid  in  1  pixel qualifier; contiguous high runs are lines.
- stats_valid  out  1  result set available.
- stats_ready  in  1  consumer accepts the result set.
- stat_sum  out  32  sum of all valid pixels in the frame.
- stat_min / stat_max  out  DATA_WIDTH each  minimum and maximum pixel value.
- stat_edges  out  20  count of horizontal edges.
- stat_lines  out  10  line count (saturating).
- stat_width  out  10  width of the first line (saturating).
- stat_width_err  out  1  some line width differed from the first line.
- overrun  out  1  sticky flag: a result set was dropped.

## Operation
- States: IDLE (ignore pixels, wait for frame_start) and ACTIVE (accumulate). Reset forces IDLE.
- frame_start in IDLE moves to ACTIVE and clears the accumulators.
- frame_start in ACTIVE does three things in one cycle:
  - closes the frame and publishes it;
  - clears the accumulators;
  - stays in ACTIVE.
- Pixel accumulation, in ACTIVE with pixel_in_valid=1:
  - sum += pixel;
  - min and max updated;
  - the run-length counter increments, saturating at 1023.
- Edge rule: if the previous cycle also had a valid pixel (same run) and |pixel − prev| ≥ EDGE_THRESH, edges += 1 (saturating at 2^20−1). The first pixel of a run never counts as an edge.
- Line end: pixel_in_valid falls while in ACTIVE.
  - lines += 1 (saturating).
  - The first line of the frame latches the width.
  - A later line whose run length ≠ the latched width sets width_err.
  - The run counter resets.
- Frame close with a run still open: the run counts as a line end before publishing.
- Empty frame (no valid pixels) publishes sum=0, min=all-ones, max=0, edges=0, lines=0, width=0, width_err=0.
- Output handshake:
  - stat_* registers are loaded only on publish and stay stable while stats_valid=1.
  - A transfer completes in a cycle with stats_valid && stats_ready.
  - Publish while stats_valid=1 and stats_ready=0: the new set is dropped, overrun is set, and the held set is unchanged.
  - Publish in the same cycle as a completing transfer: the new set is loaded, stats_valid stays 1, and overrun is not set.
- overrun is cleared only by rst.
- Pixels in IDLE are ignored.

## Timing
- Reset values: stats_valid=0, overrun=0, all stat_* = 0; accumulators cleared; state IDLE. A reset mid-frame discards the frame with no publish.
- A pixel with valid in cycle N contributes to the accumulators at edge N+1.
- Cycle ownership:
  - A pixel valid in the same cycle as frame_start belongs to the new frame.
  - A falling valid coincident with frame_start closes the old frame's run.
- stats_valid rises at the clock edge that samples frame_start (registered outputs), and is visible the cycle after frame_start.
- stats_valid falls at the edge after the accepting cycle unless a new publish coincides.
- Throughput: one pixel per clock, no stall input; frames need at least 1 cycle between frame_start pulses.

## Test plan
- Checkerboard (16-px blocks, 640 px × 480 lines, 1-cycle blanking gap per line), then frame_start with stats_ready=1 -> sum=39168000, min=0, max=255, edges=18720, lines=480, width=640, width_err=0, overrun=0.
- Horizontal gradient (pixel = x[7:0]), 640×480 -> sum=480×(2×32640+8128)=35,235,840, min=0, max=255, edges=960 (255→0 wraps at x=256 and x=512), lines=480.
- Line 3 shortened to 639 px within a 640-wide frame -> width_err=1, width=640, lines=480.
- stats_ready=0 across two frame closes -> the first set is held unchanged, overrun=1 from the second close onward. Then stats_ready=1 -> one transfer and stats_valid=0; overrun stays 1 until rst.
- frame_start coincident with stats_valid && stats_ready -> the new set is loaded, stats_valid remains 1, overrun=0.
- Two back-to-back frame_start pulses with no pixels -> an empty set is published (min=255, max=0, lines=0). In a separate run, rst asserted mid-frame -> all outputs 0, no publish, and pixels are ignored until the next frame_start.

Source files
------------

// File: rtl/frame_stats_collector_if.sv
// Pixel-stream input and per-frame statistics output bundle for frame_stats_collector.
// Latency: n/a (signal bundle only).
// Backpressure: stats_valid/stats_ready on the result side; the pixel side has no stall.
//   master: pixel source + stats consumer (drives frame_start, pixel_in*, stats_ready)
//   slave : the collector (drives stats_valid, stat_*, overrun)
interface frame_stats_collector_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  frame_start;
    logic [DATA_WIDTH-1:0] pixel_in;
    logic                  pixel_in_valid;
    logic                  stats_valid;
    logic                  stats_ready;
    logic [31:0]           stat_sum;
    logic [DATA_WIDTH-1:0] stat_min;
    logic [DATA_WIDTH-1:0] stat_max;
    logic [19:0]           stat_edges;
    logic [9:0]            stat_lines;
    logic [9:0]            stat_width;
    logic                  stat_width_err;
    logic                  overrun;

    modport master (
        output frame_start, pixel_in, pixel_in_valid, stats_ready,
        input  stats_valid, stat_sum, stat_min, stat_max, stat_edges,
               stat_lines, stat_width, stat_width_err, overrun
    );

    modport slave (
        input  frame_start, pixel_in, pixel_in_valid, stats_ready,
        output stats_valid, stat_sum, stat_min, stat_max, stat_edges,
               stat_lines, stat_width, stat_width_err, overrun
    );
endinterface

// File: rtl/frame_stats_collector.sv
// Per-frame pixel statistics (sum/min/max/edges/lines/width) published once per frame.
// Latency: pixel in cycle N lands in accumulators at edge N+1; result set valid the cycle after frame_start.
// Backpressure: none on pixels; a publish while the held set is unaccepted is dropped and sets sticky overrun.
//   Ports: clk, rst (sync, active-high); bus = slave side of frame_stats_collector_if.
module frame_stats_collector #(
    parameter int DATA_WIDTH  = 8,
    parameter int EDGE_THRESH = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    frame_stats_collector_if.slave bus
);
    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    localparam logic [9:0]            CNT10_MAX = '1;
    localparam logic [19:0]           EDGE_MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] PIX_ONES  = '1;

    state_t                state_q, state_d;

    // frame accumulators
    logic [31:0]           sum_q, sum_d;
    logic [DATA_WIDTH-1:0] min_q, min_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [19:0]           edges_q, edges_d;
    logic [9:0]            lines_q, lines_d;
    logic [9:0]            width_q, width_d;
    logic                  werr_q, werr_d;
    logic [9:0]            run_q, run_d;
    logic                  prev_vld_q, prev_vld_d;
    logic [DATA_WIDTH-1:0] prev_pix_q, prev_pix_d;

    // published result set
    logic                  st_vld_q, st_vld_d;
    logic [31:0]           st_sum_q, st_sum_d;
    logic [DATA_WIDTH-1:0] st_min_q, st_min_d;
    logic [DATA_WIDTH-1:0] st_max_q, st_max_d;
    logic [19:0]           st_edges_q, st_edges_d;
    logic [9:0]            st_lines_q, st_lines_d;
    logic [9:0]            st_width_q, st_width_d;
    logic                  st_werr_q, st_werr_d;
    logic                  overrun_q, overrun_d;

    logic                  active, take, cont, line_end, publish, xfer, edge_hit;
    logic [DATA_WIDTH-1:0] pix_diff;
    logic [9:0]            cl_lines, cl_width;
    logic                  cl_werr;

    always_comb begin
        active   = (state_q == S_ACTIVE);
        // a pixel coincident with frame_start belongs to the new frame, even out of IDLE
        take     = bus.pixel_in_valid && (active || bus.frame_start);
        // continuing a run never crosses a frame boundary
        cont     = active && prev_vld_q && bus.pixel_in_valid && !bus.frame_start;
        // a run ends on falling valid, or is force-closed by frame_start
        line_end = active && prev_vld_q && (!bus.pixel_in_valid || bus.frame_start);
        publish  = active && bus.frame_start;
        xfer     = st_vld_q && bus.stats_ready;

        pix_diff = (bus.pixel_in >= prev_pix_q) ? (bus.pixel_in - prev_pix_q)
                                                : (prev_pix_q - bus.pixel_in);
        edge_hit = (int'(pix_diff) >= EDGE_THRESH);

        // line bookkeeping with the ending run folded in; feeds both publish and carry-on
        cl_lines = (line_end && lines_q != CNT10_MAX) ? lines_q + 10'd1 : lines_q;
        cl_width = (line_end && lines_q == 10'd0) ? run_q : width_q;
        cl_werr  = werr_q | (line_end && lines_q != 10'd0 && run_q != width_q);

        state_d    = bus.frame_start ? S_ACTIVE : state_q;
        sum_d      = sum_q;
        min_d      = min_q;
        max_d      = max_q;
        edges_d    = edges_q;
        lines_d    = cl_lines;
        width_d    = cl_width;
        werr_d     = cl_werr;
        run_d      = line_end ? 10'd0 : run_q;
        prev_vld_d = take;
        prev_pix_d = take ? bus.pixel_in : prev_pix_q;

        if (bus.frame_start) begin
            sum_d   = '0;
            min_d   = PIX_ONES;
            max_d   = '0;
            edges_d = '0;
            lines_d = '0;
            width_d = '0;
            werr_d  = 1'b0;
            run_d   = '0;
        end

        if (take) begin
            sum_d = sum_d + 32'(bus.pixel_in);
            if (bus.pixel_in < min_d) min_d = bus.pixel_in;
            if (bus.pixel_in > max_d) max_d = bus.pixel_in;
            if (cont) begin
                run_d = (run_q != CNT10_MAX) ? run_q + 10'd1 : run_q;
                if (edge_hit && edges_q != EDGE_MAX) edges_d = edges_q + 20'd1;
            end else begin
                run_d = 10'd1;
            end
        end

        st_vld_d   = st_vld_q;
        st_sum_d   = st_sum_q;
        st_min_d   = st_min_q;
        st_max_d   = st_max_q;
        st_edges_d = st_edges_q;
        st_lines_d = st_lines_q;
        st_width_d = st_width_q;
        st_werr_d  = st_werr_q;
        overrun_d  = overrun_q;

        if (publish) begin
            // slot is free if empty or being drained this very cycle
            if (!st_vld_q || xfer) begin
                st_vld_d   = 1'b1;
                st_sum_d   = sum_q;
                st_min_d   = min_q;
                st_max_d   = max_q;
                st_edges_d = edges_q;
                st_lines_d = cl_lines;
                st_width_d = cl_width;
                st_werr_d  = cl_werr;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            st_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sum_q      <= '0;
            min_q      <= PIX_ONES;
            max_q      <= '0;
            edges_q    <= '0;
            lines_q    <= '0;
            width_q    <= '0;
            werr_q     <= 1'b0;
            run_q      <= '0;
            prev_vld_q <= 1'b0;
            prev_pix_q <= '0;
            st_vld_q   <= 1'b0;
            st_sum_q   <= '0;
            st_min_q   <= '0;
            st_max_q   <= '0;
            st_edges_q <= '0;
            st_lines_q <= '0;
            st_width_q <= '0;
            st_werr_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            min_q      <= min_d;
            max_q      <= max_d;
            edges_q    <= edges_d;
            lines_q    <= lines_d;
            width_q    <= width_d;
            werr_q     <= werr_d;
            run_q      <= run_d;
            prev_vld_q <= prev_vld_d;
            prev_pix_q <= prev_pix_d;
            st_vld_q   <= st_vld_d;
            st_sum_q   <= st_sum_d;
            st_min_q   <= st_min_d;
            st_max_q   <= st_max_d;
            st_edges_q <= st_edges_d;
            st_lines_q <= st_lines_d;
            st_width_q <= st_width_d;
            st_werr_q  <= st_werr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.stats_valid    = st_vld_q;
    assign bus.stat_sum       = st_sum_q;
    assign bus.stat_min       = st_min_q;
    assign bus.stat_max       = st_max_q;
    assign bus.stat_edges     = st_edges_q;
    assign bus.stat_lines     = st_lines_q;
    assign bus.stat_width     = st_width_q;
    assign bus.stat_width_err = st_werr_q;
    assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_frame_stats_collector.sv
// Bench for frame_stats_collector: table of pattern frames plus hand sequences.
// Latency: expected sets queued at the closing frame_start, compared when transferred.
// Backpressure: stats_ready held high except in the overrun / coincident-publish sequences.
module tb_frame_stats_collector;
    typedef struct {
        logic [31:0] sum;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [19:0] edges;
        logic [9:0]  lines;
        logic [9:0]  width;
        logic        werr;
    } exp_t;

    typedef struct {
        int   pat;
        int   w;
        int   h;
        int   short_ln;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    frame_stats_collector_if #(.DATA_WIDTH(8)) bus ();

    frame_stats_collector #(.DATA_WIDTH(8), .EDGE_THRESH(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // compares a transferred result set against the head of the scoreboard
    task automatic monitor();
        exp_t e;
        if (!rst && bus.stats_valid && bus.stats_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_set: got sum %0d expected no transfer", bus.stat_sum);
            end else begin
                e = sb.pop_front();
                check("sum",   bus.stat_sum, e.sum);
                check("min",   32'(bus.stat_min), 32'(e.mn));
                check("max",   32'(bus.stat_max), 32'(e.mx));
                check("edges", 32'(bus.stat_edges), 32'(e.edges));
                check("lines", 32'(bus.stat_lines), 32'(e.lines));
                check("width", 32'(bus.stat_width), 32'(e.width));
                check("werr",  32'(bus.stat_width_err), 32'(e.werr));
            end
        end
    endtask

    task automatic cyc(input logic fs, input logic vld, input logic [7:0] pix);
        bus.frame_start    = fs;
        bus.pixel_in_valid = vld;
        bus.pixel_in       = pix;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pgen(input int pat, input int x, input int y);
        case (pat)
            0:       return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 8'd255 : 8'd0;
            1:       return 8'(x);
            2:       return ((x % 2) != 0) ? 8'd128 : 8'd0;
            default: return ((x % 2) != 0) ? 8'd127 : 8'd0;
        endcase
    endfunction

    function automatic exp_t mk(input int s, input int mn, input int mx, input int ed,
                                input int ln, input int wd, input int we);
        exp_t e;
        e.sum = 32'(s); e.mn = 8'(mn); e.mx = 8'(mx); e.edges = 20'(ed);
        e.lines = 10'(ln); e.width = 10'(wd); e.werr = (we != 0);
        return e;
    endfunction

    task automatic check_outputs_zero();
        check("rst_valid",   32'(bus.stats_valid), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        check("rst_sum",     bus.stat_sum, 0);
        check("rst_min",     32'(bus.stat_min), 0);
        check("rst_max",     32'(bus.stat_max), 0);
        check("rst_edges",   32'(bus.stat_edges), 0);
        check("rst_lines",   32'(bus.stat_lines), 0);
        check("rst_width",   32'(bus.stat_width), 0);
        check("rst_werr",    32'(bus.stat_width_err), 0);
    endtask

    initial begin
        // pat, w, h, short line, {sum, min, max, edges, lines, width, werr}
        vecs[0] = '{pat: 0, w: 64,   h: 20, short_ln: -1, e: mk(163200, 0, 255, 60, 20, 64, 0)};
        vecs[1] = '{pat: 1, w: 300,  h: 2,  short_ln: -1, e: mk(67172, 0, 255, 2, 2, 300, 0)};
        vecs[2] = '{pat: 1, w: 20,   h: 4,  short_ln: 2,  e: mk(741, 0, 19, 0, 4, 20, 1)};
        vecs[3] = '{pat: 2, w: 10,   h: 1,  short_ln: -1, e: mk(640, 0, 128, 9, 1, 10, 0)};
        vecs[4] = '{pat: 3, w: 10,   h: 1,  short_ln: -1, e: mk(635, 0, 127, 0, 1, 10, 0)};
        vecs[5] = '{pat: 1, w: 1,    h: 1,  short_ln: -1, e: mk(0, 0, 0, 0, 1, 1, 0)};
        vecs[6] = '{pat: 1, w: 1100, h: 2,  short_ln: -1, e: mk(266820, 0, 255, 8, 2, 1023, 0)};

        bus.frame_start    = 1'b0;
        bus.pixel_in_valid = 1'b0;
        bus.pixel_in       = '0;
        bus.stats_ready    = 1'b1;
        rst = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst = 1'b0;
        check_outputs_zero();

        // table frames; last line's valid falls in the closing frame_start cycle
        cyc(1, 0, 0);
        for (int v = 0; v < 7; v++) begin
            for (int y = 0; y < vecs[v].h; y++) begin
                for (int x = 0; x < ((y == vecs[v].short_ln) ? vecs[v].w - 1 : vecs[v].w); x++)
                    cyc(0, 1, pgen(vecs[v].pat, x, y));
                if (y != vecs[v].h - 1) cyc(0, 0, 0);
            end
            sb.push_back(vecs[v].e);
            cyc(1, 0, 0);
        end
        cyc(0, 0, 0);

        // overrun: second close while the first set is still held
        bus.stats_ready = 1'b0;
        cyc(0, 1, 8'd5);
        cyc(0, 1, 8'd6);
        sb.push_back(mk(11, 5, 6, 0, 1, 2, 0));
        cyc(1, 0, 0);
        check("ovr_valid_a", 32'(bus.stats_valid), 1);
        check("ovr_flag_a",  32'(bus.overrun), 0);
        cyc(0, 1, 8'd100);
        cyc(1, 0, 0);
        check("ovr_flag_b",  32'(bus.overrun), 1);
        check("ovr_hold_sum", bus.stat_sum, 11);
        check("ovr_hold_max", 32'(bus.stat_max), 6);
        check("ovr_valid_b", 32'(bus.stats_valid), 1);
        bus.stats_ready = 1'b1;
        cyc(0, 0, 0);
        check("ovr_drain_valid", 32'(bus.stats_valid), 0);
        check("ovr_sticky",      32'(bus.overrun), 1);
        rst = 1'b1;
        cyc(0, 0, 0);
        rst = 1'b0;
        check("ovr_rst_flag",  32'(bus.overrun), 0);
        check("ovr_rst_valid", 32'(bus.stats_valid), 0);

        // publish coincident with a completing transfer
        cyc(1, 0, 0);
        bus.stats_ready = 1'b0;
        cyc(0, 1, 8'd1);
        cyc(0, 1, 8'd2);
        cyc(0, 1, 8'd3);
        sb.push_back(mk(6, 1, 3, 0, 1, 3, 0));
        cyc(1, 0, 0);
        cyc(0, 1, 8'd9);
        bus.stats_ready = 1'b1;
        sb.push_back(mk(9, 9, 9, 0, 1, 1, 0));
        cyc(1, 0, 0);
        check("coin_valid",   32'(bus.stats_valid), 1);
        check("coin_overrun", 32'(bus.overrun), 0);
        check("coin_sum",     bus.stat_sum, 9);

        // open run across frame_start: pixel in that cycle starts the new frame, no edge carried over
        cyc(0, 1, 8'd10);
        cyc(0, 1, 8'd20);
        cyc(0, 1, 8'd30);
        cyc(0, 1, 8'd40);
        sb.push_back(mk(100, 10, 40, 0, 1, 4, 0));
        cyc(1, 1, 8'd200);
        cyc(0, 1, 8'd210);
        cyc(0, 0, 0);
        sb.push_back(mk(410, 200, 210, 0, 1, 2, 0));
        cyc(1, 0, 0);

        // empty frame
        cyc(0, 0, 0);
        sb.push_back(mk(0, 255, 0, 0, 0, 0, 0));
        cyc(1, 0, 0);

        // reset mid-frame, then pixels in IDLE must be ignored
        cyc(0, 1, 8'd7);
        cyc(0, 1, 8'd8);
        rst = 1'b1;
        cyc(0, 1, 8'd9);
        rst = 1'b0;
        check_outputs_zero();
        cyc(0, 1, 8'd99);
        cyc(0, 1, 8'd99);
        cyc(0, 0, 0);
        check("idle_no_publish", 32'(bus.stats_valid), 0);
        cyc(1, 0, 0);
        check("open_no_publish", 32'(bus.stats_valid), 0);
        cyc(0, 1, 8'd3);
        cyc(0, 1, 8'd4);
        sb.push_back(mk(7, 3, 4, 0, 1, 2, 0));
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        check("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
